// File: rtl/mitec2_pkg.sv
// mitec2_pkg: shared state/bank encodings and default DRAM timing for the mitec2 DRAM timer
package mitec2_pkg;

    typedef enum logic [2:0] {IDLE, ROW, COL_SETUP, COL, REF, PRECHG, REF_CAS} state_t;
    typedef enum logic [1:0] {BANK_NONE, BANK1, BANK2} bank_t;

    localparam int DEF_T_RAS_MUX = 1;
    localparam int DEF_T_MUX_CAS = 1;
    localparam int DEF_T_RP      = 2;

    // A zero-cycle timing request still needs one clock to take effect
    function automatic int eff(input int p);
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/mitec2_sync.sv
// mitec2_sync: two-flop synchronizer for one asynchronous Z80 signal, resets to inactive high
module mitec2_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic d,
    output logic q
);

    logic m;

    // Metastability filter: d -> m -> q
    always_ff @(posedge CLK) begin
        if (!RESET_N) {q, m} <= 2'b11;
        else          {q, m} <= {m, d};
    end

endmodule

// File: rtl/mitec2_dram_timer.sv
// mitec2_dram_timer: RAS/CAS/MUX/RAMA7/WAIT sequencer for mitec2 cartridge DRAM
// Optional CAS-before-RAS refresh: define DRAM_CBR_REFRESH_EN
module mitec2_dram_timer
    import mitec2_pkg::*;
#(
    parameter int T_RAS_MUX = DEF_T_RAS_MUX,
    parameter int T_MUX_CAS = DEF_T_MUX_CAS,
    parameter int T_RP      = DEF_T_RP
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic MREQ,
    input  logic RD,
    input  logic WR,
    input  logic RFSH,
    input  logic A6,
    input  logic A7,
    input  logic A14,
    input  logic A15,
    output logic RAS1,
    output logic RAS2,
    output logic CAS1,
    output logic CAS2,
    output logic MUX,
    output logic RAMA7,
    output logic WAIT
);

    localparam int TRM  = eff(T_RAS_MUX);
    localparam int TMC  = eff(T_MUX_CAS);
    localparam int TRP  = eff(T_RP);
    localparam int MAXP = (TRM > TMC) ? ((TRM > TRP) ? TRM : TRP) : ((TMC > TRP) ? TMC : TRP);
    localparam int CW   = $clog2(MAXP + 1);

    logic [7:0] raw, syn;
    logic mreq_s, rd_s, wr_s, rfsh_s, a6_s, a7_s, a14_s, a15_s;
    logic unused_ok;
    bank_t hit, bank;
    state_t state;
    logic [CW-1:0] cnt;

    assign raw = {MREQ, RD, WR, RFSH, A6, A7, A14, A15};
    assign {mreq_s, rd_s, wr_s, rfsh_s, a6_s, a7_s, a14_s, a15_s} = syn;
    assign unused_ok = &{1'b0, a6_s};
    assign hit = !a15_s ? BANK_NONE : a14_s ? BANK2 : BANK1;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_sync
            mitec2_sync u_sync (.CLK(CLK), .RESET_N(RESET_N), .d(raw[i]), .q(syn[i]));
        end
    endgenerate

    // Access/refresh/precharge sequencer; every strobe is registered alongside the state
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            bank  <= BANK_NONE;
            {RAS1, RAS2, CAS1, CAS2} <= 4'b1111;
            MUX   <= 1'b0;
            RAMA7 <= 1'b1;
            WAIT  <= 1'b1;
        end else begin
            WAIT <= 1'b1;
            case (state)
                IDLE: begin
                    if (!mreq_s && rfsh_s && hit != BANK_NONE) begin
                        state <= ROW;
                        cnt   <= '0;
                        bank  <= hit;
                        RAS1  <= hit != BANK1;
                        RAS2  <= hit != BANK2;
                        MUX   <= 1'b0;
                        RAMA7 <= a7_s;
                    end else if (!mreq_s && !rfsh_s) begin
                        MUX <= 1'b0;
`ifdef DRAM_CBR_REFRESH_EN
                        state <= REF_CAS;
                        {CAS1, CAS2} <= 2'b00;
                        RAMA7 <= 1'b1;
`else
                        state <= REF;
                        {RAS1, RAS2} <= 2'b00;
                        RAMA7 <= a7_s;
`endif
                    end
                end
                PRECHG: begin
                    if (cnt == CW'(TRP - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        WAIT <= !(!mreq_s && (hit != BANK_NONE || !rfsh_s));
                    end
                end
                default: begin
                    if (mreq_s || ((state == REF || state == REF_CAS) && rfsh_s)) begin
                        state <= PRECHG;
                        cnt   <= '0;
                        {RAS1, RAS2, CAS1, CAS2} <= 4'b1111;
                        MUX   <= 1'b0;
                        RAMA7 <= 1'b1;
                    end else if (state == REF_CAS) begin
                        state <= REF;
                        {RAS1, RAS2} <= 2'b00;
                    end else if (state == ROW) begin
                        if (cnt == CW'(TRM - 1)) begin
                            state <= COL_SETUP;
                            cnt   <= '0;
                            MUX   <= 1'b1;
                            RAMA7 <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (state == COL_SETUP) begin
                        if (cnt != CW'(TMC - 1)) begin
                            cnt <= cnt + 1'b1;
                        end else if (!rd_s || !wr_s) begin
                            state <= COL;
                            CAS1  <= bank != BANK1;
                            CAS2  <= bank != BANK2;
                        end
                    end
                end
            endcase
        end
    end

endmodule
